// File: rtl/memory_responder_pkg.sv
// memory_responder shared constants
// bus width, default geometry, counter helper
package memory_responder_pkg;

  localparam int WORD_SIZE = 16;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_LATENCY = 2;
  localparam int CNT_W = 4;

  function automatic logic [CNT_W-1:0] cnt_init(input int lat);
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/memory_responder_if.sv
// memory_responder request/response handshake
// data bus travels separately as a plain inout
interface memory_responder_if
  import memory_responder_pkg::*;
#(
  parameter int WIDTH = WORD_SIZE
) ();

  logic             readM;
  logic             writeM;
  logic [WIDTH-1:0] address;
  logic             inputReady;
  logic             ackOutput;

  modport master (
    output readM,
    output writeM,
    output address,
    input  inputReady,
    input  ackOutput
  );

  modport slave (
    input  readM,
    input  writeM,
    input  address,
    output inputReady,
    output ackOutput
  );

endinterface

// File: rtl/memory_responder_mem_array.sv
// memory_responder word store
// one synchronous write port, combinational read
module memory_responder_mem_array
  import memory_responder_pkg::*;
#(
  parameter int WIDTH = WORD_SIZE,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

  // contents survive reset; only the write strobe updates them
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/memory_responder.sv
// memory_responder: bus-side responder for readM/writeM
// latency-timed handshake over a shared tri-state data bus
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic                  clk,
  input  logic                  reset_n,
  memory_responder_if.slave     bus,
  inout  wire  [WORD_SIZE-1:0]  data,
  output logic                  protocol_err,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [WORD_SIZE-1:0]  load_data
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] READ_WAIT  = 3'd1;
  localparam logic [2:0] READ_RESP  = 3'd2;
  localparam logic [2:0] WRITE_WAIT = 3'd3;
  localparam logic [2:0] WRITE_RESP = 3'd4;

  logic [2:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [WORD_SIZE-1:0]  lat_data;
  logic                  ready;
  logic                  ack;
  logic                  perr;

  logic                  bus_oe;
  logic                  commit;
  logic                  load_ok;
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [WORD_SIZE-1:0]  wdata;
  logic [WORD_SIZE-1:0]  rdata;

  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.address[WORD_SIZE-1:ADDR_WIDTH];

  // request/wait/response sequencing; reset aborts anything in flight
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      ready <= 1'b0;
      ack   <= 1'b0;
      perr  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.readM) begin
            lat_addr <= bus.address[ADDR_WIDTH-1:0];
            cnt      <= cnt_init(LATENCY);
            state    <= READ_WAIT;
            if (bus.writeM) perr <= 1'b1;
          end else if (bus.writeM) begin
            lat_addr <= bus.address[ADDR_WIDTH-1:0];
            lat_data <= data;
            cnt      <= cnt_init(LATENCY);
            state    <= WRITE_WAIT;
          end
        end
        READ_WAIT: begin
          if (!bus.readM) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            state <= READ_RESP;
            ready <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        READ_RESP: begin
          if (!bus.readM) begin
            state <= IDLE;
            ready <= 1'b0;
          end
        end
        WRITE_WAIT: begin
          if (!bus.writeM) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            state <= WRITE_RESP;
            ack   <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WRITE_RESP: begin
          if (!bus.writeM) begin
            state <= IDLE;
            ack   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // single write port: responder commit wins, backdoor only when idle and quiet
  always_comb begin
    commit  = (state == WRITE_WAIT) && bus.writeM && (cnt == '0);
    load_ok = load_en && (state == IDLE) && !bus.readM && !bus.writeM;
    we      = reset_n && (commit || load_ok);
    waddr   = commit ? lat_addr : load_addr;
    wdata   = commit ? lat_data : load_data;
  end

  memory_responder_mem_array #(
    .WIDTH      (WORD_SIZE),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (lat_addr),
    .rdata (rdata)
  );

  assign bus_oe         = (state == READ_RESP);
  assign data           = bus_oe ? rdata : 'z;
  assign bus.inputReady = ready;
  assign bus.ackOutput  = ack;
  assign protocol_err   = perr;

endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: directed checks of the bus responder
// dut0 uses LATENCY=2, dut1 uses LATENCY=1
module tb_memory_responder;

  logic clk = 1'b0;
  logic reset_n;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  memory_responder_if #(.WIDTH(16)) bus0 ();
  memory_responder_if #(.WIDTH(16)) bus1 ();

  wire  [15:0] data0;
  wire  [15:0] data1;
  logic        oe0, oe1;
  logic [15:0] drv0, drv1;
  logic        perr0, perr1;
  logic        ld_en0, ld_en1;
  logic [7:0]  ld_addr0, ld_addr1;
  logic [15:0] ld_data0, ld_data1;

  assign data0 = oe0 ? drv0 : 'z;
  assign data1 = oe1 ? drv1 : 'z;

  memory_responder #(.ADDR_WIDTH(8), .LATENCY(2)) dut0 (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus0),
    .data         (data0),
    .protocol_err (perr0),
    .load_en      (ld_en0),
    .load_addr    (ld_addr0),
    .load_data    (ld_data0)
  );

  memory_responder #(.ADDR_WIDTH(8), .LATENCY(1)) dut1 (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus1),
    .data         (data1),
    .protocol_err (perr1),
    .load_en      (ld_en1),
    .load_addr    (ld_addr1),
    .load_data    (ld_data1)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load0(input logic [7:0] a, input logic [15:0] d);
    ld_en0 = 1'b1;
    ld_addr0 = a;
    ld_data0 = d;
    tick();
    ld_en0 = 1'b0;
  endtask

  // returns edges from acceptance to inputReady, -1 on timeout
  task automatic read0(input logic [15:0] a, output logic [15:0] v,
                       output int lat);
    bus0.readM = 1'b1;
    bus0.address = a;
    v = 'x;
    lat = -1;
    tick();
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus0.inputReady) begin
        lat = i;
        v = data0;
        break;
      end
    end
    bus0.readM = 1'b0;
    tick();
  endtask

  task automatic write0(input logic [15:0] a, input logic [15:0] d,
                        output int lat);
    bus0.writeM = 1'b1;
    bus0.address = a;
    oe0 = 1'b1;
    drv0 = d;
    lat = -1;
    tick();
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus0.ackOutput) begin
        lat = i;
        break;
      end
    end
    bus0.writeM = 1'b0;
    oe0 = 1'b0;
    tick();
  endtask

  logic [15:0] v;
  int lat;
  logic seen;

  initial begin
    reset_n = 1'b0;
    bus0.readM = 0; bus0.writeM = 0; bus0.address = 0;
    bus1.readM = 0; bus1.writeM = 0; bus1.address = 0;
    oe0 = 0; oe1 = 0; drv0 = 0; drv1 = 0;
    ld_en0 = 0; ld_en1 = 0;
    ld_addr0 = 0; ld_addr1 = 0; ld_data0 = 0; ld_data1 = 0;
    tick();
    tick();
    reset_n = 1'b1;
    chk("rst_ready", 32'(bus0.inputReady), 32'd0);
    chk("rst_ack", 32'(bus0.ackOutput), 32'd0);
    chk("rst_perr", 32'(perr0), 32'd0);
    chk("rst_oe", 32'(dut0.bus_oe), 32'd0);

    load0(8'h10, 16'hBEEF);
    load0(8'h30, 16'h5555);
    load0(8'h40, 16'h1111);
    load0(8'h60, 16'h6666);

    // basic read with address change during wait
    bus0.readM = 1'b1;
    bus0.address = 16'h0010;
    tick();
    chk("rd_e0", 32'(bus0.inputReady), 32'd0);
    bus0.address = 16'h0030;
    tick();
    chk("rd_e1", 32'(bus0.inputReady), 32'd0);
    tick();
    chk("rd_e2_rdy", 32'(bus0.inputReady), 32'd1);
    chk("rd_e2_data", 32'(data0), 32'hBEEF);
    tick();
    chk("rd_hold", 32'(bus0.inputReady), 32'd1);
    bus0.readM = 1'b0;
    tick();
    chk("rd_drop_rdy", 32'(bus0.inputReady), 32'd0);
    chk("rd_drop_oe", 32'(dut0.bus_oe), 32'd0);
    tick();

    // write with data change during wait
    bus0.writeM = 1'b1;
    bus0.address = 16'h0020;
    oe0 = 1'b1;
    drv0 = 16'h1234;
    tick();
    drv0 = 16'hFFFF;
    tick();
    chk("wr_e1", 32'(bus0.ackOutput), 32'd0);
    tick();
    chk("wr_e2_ack", 32'(bus0.ackOutput), 32'd1);
    bus0.writeM = 1'b0;
    oe0 = 1'b0;
    tick();
    chk("wr_drop_ack", 32'(bus0.ackOutput), 32'd0);
    tick();

    read0(16'h0020, v, lat);
    chk("rb_lat", 32'(lat), 32'd2);
    chk("rb_data", 32'(v), 32'h1234);
    read0(16'h0120, v, lat);
    chk("wrap_data", 32'(v), 32'h1234);

    // read aborted one edge after acceptance
    bus0.readM = 1'b1;
    bus0.address = 16'h0010;
    tick();
    bus0.readM = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen = seen | bus0.inputReady;
    end
    chk("rd_abort", 32'(seen), 32'd0);

    // write aborted one edge after acceptance
    bus0.writeM = 1'b1;
    bus0.address = 16'h0030;
    oe0 = 1'b1;
    drv0 = 16'hAAAA;
    tick();
    bus0.writeM = 1'b0;
    oe0 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen = seen | bus0.ackOutput;
    end
    chk("wr_abort_ack", 32'(seen), 32'd0);
    read0(16'h0030, v, lat);
    chk("wr_abort_mem", 32'(v), 32'h5555);

    // backdoor load ignored while a read is in flight
    bus0.readM = 1'b1;
    bus0.address = 16'h0050;
    tick();
    ld_en0 = 1'b1;
    ld_addr0 = 8'h40;
    ld_data0 = 16'h2222;
    tick();
    ld_en0 = 1'b0;
    bus0.readM = 1'b0;
    tick();
    tick();
    read0(16'h0040, v, lat);
    chk("ld_busy_ign", 32'(v), 32'h1111);

    // simultaneous requests: read wins, error sticks
    bus0.readM = 1'b1;
    bus0.writeM = 1'b1;
    bus0.address = 16'h0010;
    oe0 = 1'b1;
    drv0 = 16'hDEAD;
    tick();
    chk("both_perr", 32'(perr0), 32'd1);
    oe0 = 1'b0;
    tick();
    tick();
    chk("both_rdy", 32'(bus0.inputReady), 32'd1);
    chk("both_data", 32'(data0), 32'hBEEF);
    bus0.readM = 1'b0;
    bus0.writeM = 1'b0;
    tick();
    chk("both_ack", 32'(bus0.ackOutput), 32'd0);
    tick();
    read0(16'h0010, v, lat);
    chk("both_nowr", 32'(v), 32'hBEEF);
    chk("perr_sticky", 32'(perr0), 32'd1);

    // reset on the edge that would commit the write
    bus0.writeM = 1'b1;
    bus0.address = 16'h0060;
    oe0 = 1'b1;
    drv0 = 16'h7777;
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    bus0.writeM = 1'b0;
    oe0 = 1'b0;
    chk("mid_rst_ack", 32'(bus0.ackOutput), 32'd0);
    chk("mid_rst_rdy", 32'(bus0.inputReady), 32'd0);
    chk("mid_rst_perr", 32'(perr0), 32'd0);
    chk("mid_rst_oe", 32'(dut0.bus_oe), 32'd0);
    tick();
    read0(16'h0060, v, lat);
    chk("mid_rst_mem", 32'(v), 32'h6666);

    // LATENCY=1 instance: write then read back
    bus1.writeM = 1'b1;
    bus1.address = 16'h0020;
    oe1 = 1'b1;
    drv1 = 16'hABCD;
    tick();
    chk("l1_wr_e0", 32'(bus1.ackOutput), 32'd0);
    tick();
    chk("l1_wr_e1", 32'(bus1.ackOutput), 32'd1);
    bus1.writeM = 1'b0;
    oe1 = 1'b0;
    tick();
    chk("l1_wr_drop", 32'(bus1.ackOutput), 32'd0);
    bus1.readM = 1'b1;
    bus1.address = 16'h0220;
    tick();
    chk("l1_rd_e0", 32'(bus1.inputReady), 32'd0);
    tick();
    chk("l1_rd_e1", 32'(bus1.inputReady), 32'd1);
    chk("l1_rd_data", 32'(data1), 32'hABCD);
    bus1.readM = 1'b0;
    tick();
    chk("l1_rd_drop", 32'(bus1.inputReady), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
